traffic_arbiter: RTL and testbench

TRAFFIC_ARBITER -- requirements
Module: traffic_arbiter

---
 rtl/traffic_pkg.sv | 28 ++
 rtl/traffic_arbiter_rr_picker.sv | 18 +
 rtl/traffic_arbiter.sv | 98 +++++++++
 tb/tb_traffic_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: light/direction codes and arbiter state encoding shared by the traffic arbiter.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam logic [1:0] N = 2'd0;
    localparam logic [1:0] W = 2'd1;
    localparam logic [1:0] S = 2'd2;
    localparam logic [1:0] E = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YELLOW,
        ST_ALLRED,
        ST_EMG
    } state_t;

    // Only the active approach can leave red; everything else is forced red.
    function automatic logic [2:0] light_of(input state_t st, input logic [1:0] dir, input logic [1:0] me);
        return (dir != me) ? RED :
               (st == ST_GREEN || st == ST_EMG) ? GREEN :
               (st == ST_YELLOW) ? YELLOW : RED;
    endfunction

endpackage

// File: rtl/traffic_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector, first requesting approach after rr_ptr.
module rr_picker (
    input  logic [3:0] req,
    input  logic [1:0] rr_ptr,
    output logic [1:0] winner,
    output logic       any
);

    // Scan from the farthest offset down so the nearest requester after rr_ptr wins.
    always_comb begin
        winner = rr_ptr;
        any = |req;
        for (int i = 4; i >= 1; i--) begin
            if (req[2'(rr_ptr + 2'(i))]) winner = 2'(rr_ptr + 2'(i));
        end
    end

endmodule

// File: rtl/traffic_arbiter.sv
// traffic_arbiter: four-way intersection controller with round-robin service and emergency preemption.
module traffic_arbiter
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 15,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       emg_valid,
    input  logic [1:0] emg_dir,
    output logic       emg_ack,
    output logic [2:0] north_light,
    output logic [2:0] west_light,
    output logic [2:0] south_light,
    output logic [2:0] east_light,
    output logic [1:0] active_dir,
    output logic [3:0] phase_count
);

    localparam logic [3:0] MIN_LAST = 4'(MIN_GREEN - 1);
    localparam logic [3:0] MAX_LAST = 4'(MAX_GREEN - 1);
    localparam logic [3:0] YEL_LAST = 4'(YELLOW_T - 1);
    localparam logic [3:0] AR_LAST  = 4'(ALLRED_T - 1);

    state_t     state_q, state_d;
    logic [1:0] dir_q, dir_d, rr_q, rr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] winner;
    logic       any, pick, emg_hold, others;

    rr_picker u_pick (
        .req    (req),
        .rr_ptr (rr_q),
        .winner (winner),
        .any    (any)
    );

    assign emg_hold = emg_valid && emg_dir == dir_q;
    assign others   = |(req & ~(4'b0001 << dir_q));

    always_comb begin
        state_d = state_q;
        dir_d = dir_q;
        rr_d = rr_q;
        pick = 1'b0;
        case (state_q)
            ST_IDLE:   pick = 1'b1;
            ST_GREEN: begin
                if (emg_valid) state_d = (emg_dir == dir_q) ? ST_EMG : ST_YELLOW;
                else if ((cnt_q >= MIN_LAST && !req[dir_q]) || (cnt_q >= MAX_LAST && others)) state_d = ST_YELLOW;
            end
            ST_YELLOW: if (cnt_q == YEL_LAST) state_d = ST_ALLRED;
            ST_ALLRED: if (cnt_q == AR_LAST) begin
                pick = 1'b1;
                state_d = ST_IDLE;
            end
            ST_EMG:    if (!emg_hold) state_d = ST_YELLOW;
            default:   state_d = ST_IDLE;
        endcase
        // Emergency outranks normal demand; only normal grants advance the rotation.
        if (pick && emg_valid) begin
            state_d = ST_EMG;
            dir_d = emg_dir;
        end else if (pick && any) begin
            state_d = ST_GREEN;
            dir_d = winner;
            rr_d = winner;
        end
        cnt_d = (state_d != state_q) ? 4'd0 : (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dir_q <= N;
            rr_q <= E;
            cnt_q <= 4'd0;
        end else begin
            state_q <= state_d;
            dir_q <= dir_d;
            rr_q <= rr_d;
            cnt_q <= cnt_d;
        end
    end

    assign emg_ack     = state_q == ST_EMG && emg_hold;
    assign active_dir  = dir_q;
    assign phase_count = cnt_q;
    assign north_light = light_of(state_q, dir_q, N);
    assign west_light  = light_of(state_q, dir_q, W);
    assign south_light = light_of(state_q, dir_q, S);
    assign east_light  = light_of(state_q, dir_q, E);

endmodule

// File: tb/tb_traffic_arbiter.sv
// tb_traffic_arbiter: scenario tests; expected light/phase sequences queued up front, popped each cycle.
module tb_traffic_arbiter;

    logic       clk = 1'b0, reset = 1'b0;
    logic [3:0] req = 4'd0;
    logic       emg_valid = 1'b0;
    logic [1:0] emg_dir = 2'd0;
    logic       emg_ack;
    logic [2:0] north_light, west_light, south_light, east_light;
    logic [1:0] active_dir;
    logic [3:0] phase_count;

    int errors = 0, checks = 0;

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001;

    typedef struct packed {
        logic [11:0] lt;
        logic [3:0]  pc;
        logic [1:0]  dir;
        logic        ack;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    traffic_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .emg_valid   (emg_valid),
        .emg_dir     (emg_dir),
        .emg_ack     (emg_ack),
        .north_light (north_light),
        .west_light  (west_light),
        .south_light (south_light),
        .east_light  (east_light),
        .active_dir  (active_dir),
        .phase_count (phase_count)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] mk(input logic [1:0] d, input logic [2:0] c);
        logic [11:0] v = {R, R, R, R};
        v[int'(d) * 3 +: 3] = c;
        return v;
    endfunction

    function automatic exp_t obs();
        return '{{east_light, south_light, west_light, north_light}, phase_count, active_dir, emg_ack};
    endfunction

    function automatic string fmt(input exp_t x);
        return $sformatf("lights(ESWN)=%h pc=%0d dir=%0d ack=%b", x.lt, x.pc, x.dir, x.ack);
    endfunction

    task automatic push(input logic [1:0] d, input logic [2:0] c, input int n, input int pc0, input logic ack);
        for (int i = 0; i < n; i++)
            sb.push_back('{mk(d, c), 4'((pc0 + i > 15) ? 15 : pc0 + i), d, ack});
    endtask

    task automatic reset_dut();
        req = 4'd0;
        emg_valid = 1'b0;
        emg_dir = 2'd0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs() !== '{mk(2'd0, R), 4'd0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_async: got %s want all red pc=0 dir=0 ack=0", fmt(obs()));
        end
        req = 4'hF;
        emg_valid = 1'b1;
        emg_dir = 2'd2;
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== '{mk(2'd0, R), 4'd0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_held: got %s want all red pc=0 dir=0 ack=0", fmt(obs()));
        end
        reset_dut();
    endtask

    task automatic test_single();
        int n;
        reset_dut();
        req = 4'b0001;
        push(2'd0, G, 20, 0, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL single[%0d]: got %s want %s", i, fmt(obs()), fmt(e));
            end
        end
    endtask

    task automatic test_contest();
        int n;
        reset_dut();
        req = 4'b0001;
        push(2'd0, G, 15, 0, 1'b0);
        push(2'd0, Y, 3, 0, 1'b0);
        push(2'd0, R, 1, 0, 1'b0);
        push(2'd1, G, 3, 0, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL contest[%0d]: got %s want %s", i, fmt(obs()), fmt(e));
            end
            if (i == 0) req = 4'b0011;
        end
    endtask

    task automatic test_drop();
        int n;
        reset_dut();
        req = 4'b0001;
        push(2'd0, G, 4, 0, 1'b0);
        push(2'd0, Y, 3, 0, 1'b0);
        push(2'd0, R, 1, 0, 1'b0);
        push(2'd0, R, 2, 0, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL drop[%0d]: got %s want %s", i, fmt(obs()), fmt(e));
            end
            if (i == 1) req = 4'b0000;
        end
    endtask

    task automatic test_emg();
        int n;
        reset_dut();
        req = 4'b0100;
        push(2'd2, G, 1, 0, 1'b0);
        push(2'd2, Y, 3, 0, 1'b0);
        push(2'd2, R, 1, 0, 1'b0);
        push(2'd3, G, 3, 0, 1'b1);
        push(2'd3, Y, 3, 0, 1'b0);
        push(2'd3, R, 1, 0, 1'b0);
        push(2'd3, G, 1, 0, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL emg[%0d]: got %s want %s", i, fmt(obs()), fmt(e));
            end
            if (i == 0) begin
                emg_valid = 1'b1;
                emg_dir = 2'd3;
                req = 4'b1001;
            end
            if (i == 7) emg_valid = 1'b0;
        end
    endtask

    task automatic test_emg_same();
        int n;
        reset_dut();
        req = 4'b0001;
        push(2'd0, G, 1, 0, 1'b0);
        push(2'd0, G, 2, 0, 1'b1);
        push(2'd0, Y, 1, 0, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL emg_same[%0d]: got %s want %s", i, fmt(obs()), fmt(e));
            end
            if (i == 0) begin
                emg_valid = 1'b1;
                emg_dir = 2'd0;
            end
            if (i == 2) begin
                emg_valid = 1'b0;
                req = 4'b0000;
            end
        end
    endtask

    task automatic test_reset_yellow();
        int n;
        reset_dut();
        req = 4'b0010;
        push(2'd1, G, 4, 0, 1'b0);
        push(2'd1, Y, 2, 0, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL reset_yel[%0d]: got %s want %s", i, fmt(obs()), fmt(e));
            end
            if (i == 0) req = 4'b0000;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs() !== '{mk(2'd0, R), 4'd0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_yellow: got %s want all red pc=0 dir=0 ack=0", fmt(obs()));
        end
        @(negedge clk);
        reset = 1'b0;
        req = 4'b1000;
        push(2'd3, G, 2, 0, 1'b0);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL after_reset[%0d]: got %s want %s", i, fmt(obs()), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contest();
        test_drop();
        test_emg();
        test_emg_same();
        test_reset_yellow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
